// File: rtl/cmp8b_window_minmax.sv
// Windowed running max/min over an unsigned sample stream.
// Presents max, min, first-occurrence indices and span per window.
module cmp8b_window_minmax #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] MIN,
  output logic [IDX_W-1:0] MAX_IDX,
  output logic [IDX_W-1:0] MIN_IDX,
  output logic [WIDTH-1:0] SPAN
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             first;
  logic             take_max;
  logic             take_min;
  logic [WIDTH-1:0] max_nxt;
  logic [WIDTH-1:0] min_nxt;

  assign accept = IN_VALID && IN_READY && !CLR;
  assign last   = cnt == IDX_W'(WINDOW - 1);
  assign first  = cnt == '0;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (CLR) begin
      state_nxt = ACCUM;
    end else begin
      unique case (state)
        ACCUM: if (accept && last) state_nxt = HOLD;
        HOLD:  if (OUT_READY)      state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    IN_READY  = state == ACCUM;
    OUT_VALID = state == HOLD;
  end

  // Strict compares: ties keep the earliest index.
  always_comb begin
    take_max = first || (IN_DATA > MAX);
    take_min = first || (IN_DATA < MIN);
    max_nxt  = take_max ? IN_DATA : MAX;
    min_nxt  = take_min ? IN_DATA : MIN;
  end

  always_ff @(posedge clk) begin
    if (rst || CLR) begin
      cnt     <= '0;
      MAX     <= '0;
      MIN     <= '0;
      MAX_IDX <= '0;
      MIN_IDX <= '0;
      SPAN    <= '0;
    end else if (accept) begin
      cnt  <= last ? '0 : cnt + 1'b1;
      MAX  <= max_nxt;
      MIN  <= min_nxt;
      SPAN <= max_nxt - min_nxt;
      if (take_max) MAX_IDX <= cnt;
      if (take_min) MIN_IDX <= cnt;
    end else if (state == HOLD && OUT_READY) begin
      cnt <= '0;
    end
  end

endmodule

// File: doc/cmp8b_window_minmax.md
Name: cmp8b_window_minmax

Overview:
- Sequential stage directly downstream of the 8-bit unsigned comparator.
- Accepts a stream of unsigned samples over a valid/ready handshake. Each accepted sample is compared, unsigned, against the running maximum and running minimum.
- After WINDOW samples, presents max, min, their indices and span on an output handshake, holding them until consumed.
- Used for peak/trough detection on sampled data before downstream decision logic.

Parameters:
- WIDTH, 8, sample width in bits; all comparisons are unsigned.
- WINDOW, 16, samples per result window; legal range 2..2^IDX_W.
- IDX_W, 4, width of sample index outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- CLR  input  1  synchronous window abort; discards partial window.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  block can accept a sample.
- IN_DATA  input  WIDTH  unsigned sample.
- OUT_VALID  output  1  window result valid.
- OUT_READY  input  1  consumer takes result.
- MAX  output  WIDTH  largest sample in window.
- MIN  output  WIDTH  smallest sample in window.
- MAX_IDX  output  IDX_W  position (0-based) of first occurrence of MAX.
- MIN_IDX  output  IDX_W  position of first occurrence of MIN.
- SPAN  output  WIDTH  MAX minus MIN; never negative.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Reset values after a clock edge with rst=1:
  - state=ACCUM, sample counter=0.
  - OUT_VALID=0.
  - MAX=0, MIN=0, MAX_IDX=0, MIN_IDX=0, SPAN=0.
- IN_READY is combinational: 1 iff state==ACCUM.
- Sample acceptance: a sample is accepted on an edge with IN_VALID & IN_READY.
- FSM, two states:
  - ACCUM: accept samples. On the accepted sample with counter==WINDOW-1, go to HOLD and set OUT_VALID=1 on that same edge. Result latency is one cycle after the final accepted sample.
  - HOLD: IN_READY=0. MAX, MIN, MAX_IDX, MIN_IDX and SPAN are stable. On an edge with OUT_READY=1: OUT_VALID←0, counter←0, return to ACCUM. OUT_READY is ignored while OUT_VALID=0.
- Update rules per accepted sample with index k=counter:
  - k==0: MAX←IN_DATA, MIN←IN_DATA, MAX_IDX←0, MIN_IDX←0.
  - k>0, IN_DATA > MAX (strict, unsigned): MAX←IN_DATA, MAX_IDX←k.
  - k>0, IN_DATA < MIN (strict): MIN←IN_DATA, MIN_IDX←k.
  - Equal values never update, so ties keep the earliest index.
  - A sample may update both MAX and MIN only at k==0.
  - counter←k+1 on each accepted sample, and returns to 0 when the window completes.
- SPAN: registered as MAX−MIN, WIDTH bits. It is computed from the post-update values and is valid whenever OUT_VALID=1. The result is always non-negative because MAX≥MIN by construction.
- MAX/MIN/IDX/SPAN during ACCUM: reflect the partial window. These values are not guaranteed meaningful until OUT_VALID=1.
- CLR behaviour:
  - Effect in any state: state←ACCUM, counter←0, OUT_VALID←0, and the result registers clear to their reset values.
  - CLR takes priority over a simultaneous accept or OUT_READY. A sample presented in the same cycle as CLR is not consumed, even though IN_READY may be 1.
- rst priority: rst has priority over CLR and over both handshakes. Reset mid-window or mid-HOLD drops all data.
- Extremes: samples 0 and 2^WIDTH−1 are legal. Comparisons never wrap.
- IN_VALID held low: no state change in ACCUM; gaps between samples are allowed.

Test Plan:
- rst for 2 cycles, then idle -> IN_READY=1, OUT_VALID=0, and MAX, MIN, MAX_IDX, MIN_IDX and SPAN all 0.
- WINDOW=4, back-to-back samples 10,200,3,200 -> OUT_VALID one cycle after the 4th accept; MAX=200, MAX_IDX=1 (tie keeps first), MIN=3, MIN_IDX=2, SPAN=197; IN_READY=0 while held.
- WINDOW=4, samples 0,255,255,0 with IN_VALID gaps of 1–3 cycles -> MAX=255, MAX_IDX=1, MIN=0, MIN_IDX=0, SPAN=255.
- Hold OUT_READY=0 for 5 cycles after OUT_VALID while driving IN_VALID=1 -> no sample is consumed and outputs are stable. Then OUT_READY=1 for one cycle -> OUT_VALID=0 next cycle, IN_READY=1, and the next window starts at index 0.
- Assert CLR after 2 of 4 samples, in the same cycle as IN_VALID=1 with data 7 -> the sample is not consumed and registers clear. The next 4 samples 5,5,5,5 give MAX=MIN=5, both indices 0, SPAN=0.
- Assert rst while in HOLD, simultaneous with OUT_READY=1 -> next cycle all outputs are at reset values and IN_READY=1.
